// File: rtl/ibex_l2_rf_arbiter.sv
// Shares the single-port L2 register file between requesters A and B with round-robin
// arbitration, registered responses, address range checking and a zeroing scrub sequencer.
module ibex_l2_rf_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumWords  = 28
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_a_valid_i,
  output logic                 req_a_ready_o,
  input  logic                 req_a_we_i,
  input  logic [4:0]           req_a_addr_i,
  input  logic [DataWidth-1:0] req_a_wdata_i,
  output logic                 rsp_a_valid_o,
  output logic [DataWidth-1:0] rsp_a_rdata_o,
  output logic                 rsp_a_err_o,
  input  logic                 req_b_valid_i,
  output logic                 req_b_ready_o,
  input  logic                 req_b_we_i,
  input  logic [4:0]           req_b_addr_i,
  input  logic [DataWidth-1:0] req_b_wdata_i,
  output logic                 rsp_b_valid_o,
  output logic [DataWidth-1:0] rsp_b_rdata_o,
  output logic                 rsp_b_err_o,
  input  logic                 scrub_req_i,
  output logic                 scrub_busy_o,
  output logic                 scrub_done_o,
  output logic [4:0]           rf_addr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  input  logic [DataWidth-1:0] rf_rdata_i,
  output logic                 fsm_state_o
);

  localparam logic [5:0] NumWordsW = 6'(NumWords);
  localparam logic [4:0] LastIdx   = 5'(NumWords - 1);

  // Handshake: ready is combinational and equals the grant; a transfer happens on a
  // cycle where valid & ready, and its response pulses rsp_valid the following cycle.
  typedef enum logic {StIdle = 1'b0, StScrub = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [4:0]           scrub_idx_q, scrub_idx_d;
  logic                 scrub_done_q, scrub_done_d;
  logic                 last_grant_q;  // 0 = A, 1 = B
  logic                 grant_a, grant_b;
  logic                 sel_we;
  logic [4:0]           sel_addr;
  logic [DataWidth-1:0] sel_wdata;
  logic                 sel_addr_ok;
  logic [DataWidth-1:0] rsp_rdata_d;
  logic                 rsp_err_d;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      scrub_idx_q  <= 5'd1;
      scrub_done_q <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      scrub_idx_q  <= scrub_idx_d;
      scrub_done_q <= scrub_done_d;
      if (grant_a) begin
        last_grant_q <= 1'b0;
      end else if (grant_b) begin
        last_grant_q <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    scrub_idx_d  = scrub_idx_q;
    scrub_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (scrub_req_i) begin
          state_d = StScrub;
        end
      end
      StScrub: begin
        if (scrub_idx_q == LastIdx) begin
          state_d      = StIdle;
          scrub_idx_d  = 5'd1;
          scrub_done_d = 1'b1;
        end else begin
          scrub_idx_d = scrub_idx_q + 5'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: arbitration and register file drive
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == StIdle && !scrub_req_i) begin
      if (req_a_valid_i && req_b_valid_i) begin
        grant_a = last_grant_q;
        grant_b = !last_grant_q;
      end else begin
        grant_a = req_a_valid_i;
        grant_b = req_b_valid_i;
      end
    end

    sel_we      = grant_b ? req_b_we_i    : req_a_we_i;
    sel_addr    = grant_b ? req_b_addr_i  : req_a_addr_i;
    sel_wdata   = grant_b ? req_b_wdata_i : req_a_wdata_i;
    sel_addr_ok = {1'b0, sel_addr} < NumWordsW;

    rf_addr_o  = '0;
    rf_wdata_o = '0;
    rf_we_o    = 1'b0;
    if (state_q == StScrub) begin
      rf_addr_o = scrub_idx_q;
      rf_we_o   = 1'b1;
    end else if (grant_a || grant_b) begin
      rf_addr_o  = sel_addr;
      rf_wdata_o = sel_wdata;
      // Word 0 is hardwired to zero, so writes to it never reach the file.
      rf_we_o    = sel_we && sel_addr_ok && (sel_addr != 5'd0);
    end

    req_a_ready_o = grant_a;
    req_b_ready_o = grant_b;
    scrub_busy_o  = (state_q == StScrub);
    scrub_done_o  = scrub_done_q;
    fsm_state_o   = (state_q == StScrub);
  end

  assign rsp_err_d   = !sel_addr_ok;
  assign rsp_rdata_d = (!sel_we && sel_addr_ok && sel_addr != 5'd0) ? rf_rdata_i : '0;

  // Responses; the ungranted side keeps its last rdata/err.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_a_valid_o <= 1'b0;
      rsp_a_rdata_o <= '0;
      rsp_a_err_o   <= 1'b0;
      rsp_b_valid_o <= 1'b0;
      rsp_b_rdata_o <= '0;
      rsp_b_err_o   <= 1'b0;
    end else begin
      rsp_a_valid_o <= grant_a;
      rsp_b_valid_o <= grant_b;
      if (grant_a) begin
        rsp_a_rdata_o <= rsp_rdata_d;
        rsp_a_err_o   <= rsp_err_d;
      end
      if (grant_b) begin
        rsp_b_rdata_o <= rsp_rdata_d;
        rsp_b_err_o   <= rsp_err_d;
      end
    end
  end

endmodule

// File: tb/tb_ibex_l2_rf_arbiter.sv
// Bench for ibex_l2_rf_arbiter: a register file model, a response scoreboard per requester
// and scenario tasks for arbitration, access path, errors and scrub.
module tb_ibex_l2_rf_arbiter;
  localparam int DW = 32;
  localparam int NW = 28;
  localparam int W  = DW + 1;  // {err, rdata}

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, a_ready, a_we, b_valid, b_ready, b_we;
  logic [4:0]    a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          rsp_a_valid, rsp_a_err, rsp_b_valid, rsp_b_err;
  logic [DW-1:0] rsp_a_rdata, rsp_b_rdata;
  logic          scrub_req, scrub_busy, scrub_done, rf_we, fsm_state;
  logic [4:0]    rf_addr;
  logic [DW-1:0] rf_wdata, rf_rdata;

  logic [DW-1:0] rf_mem  [32];
  logic [DW-1:0] ref_mem [32];
  logic [W-1:0]  exp_a_q [$];
  logic [W-1:0]  exp_b_q [$];
  logic [W-1:0]  exp_v;
  logic          tb_last = 1'b1;
  int            checks = 0;
  int            errors = 0;

  ibex_l2_rf_arbiter #(.DataWidth(DW), .NumWords(NW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_a_valid_i(a_valid), .req_a_ready_o(a_ready), .req_a_we_i(a_we),
    .req_a_addr_i(a_addr), .req_a_wdata_i(a_wdata),
    .rsp_a_valid_o(rsp_a_valid), .rsp_a_rdata_o(rsp_a_rdata), .rsp_a_err_o(rsp_a_err),
    .req_b_valid_i(b_valid), .req_b_ready_o(b_ready), .req_b_we_i(b_we),
    .req_b_addr_i(b_addr), .req_b_wdata_i(b_wdata),
    .rsp_b_valid_o(rsp_b_valid), .rsp_b_rdata_o(rsp_b_rdata), .rsp_b_err_o(rsp_b_err),
    .scrub_req_i(scrub_req), .scrub_busy_o(scrub_busy), .scrub_done_o(scrub_done),
    .rf_addr_o(rf_addr), .rf_wdata_o(rf_wdata), .rf_we_o(rf_we), .rf_rdata_i(rf_rdata),
    .fsm_state_o(fsm_state)
  );

  // Clock and register file model
  always #5 clk = ~clk;
  always @(posedge clk) if (rf_we) rf_mem[rf_addr] <= rf_wdata;
  assign rf_rdata = rf_mem[rf_addr];

  // Scoreboard: pop and compare whenever a response pulses
  always @(negedge clk) begin
    if (rst_n && rsp_a_valid) begin
      checks++;
      if (exp_a_q.size() == 0) begin
        errors++; $display("FAIL rsp_a_unexpected: got %h required none", {rsp_a_err, rsp_a_rdata});
      end else begin
        exp_v = exp_a_q.pop_front();
        if ({rsp_a_err, rsp_a_rdata} !== exp_v) begin
          errors++; $display("FAIL rsp_a: got %h required %h", {rsp_a_err, rsp_a_rdata}, exp_v);
        end
      end
    end
    if (rst_n && rsp_b_valid) begin
      checks++;
      if (exp_b_q.size() == 0) begin
        errors++; $display("FAIL rsp_b_unexpected: got %h required none", {rsp_b_err, rsp_b_rdata});
      end else begin
        exp_v = exp_b_q.pop_front();
        if ({rsp_b_err, rsp_b_rdata} !== exp_v) begin
          errors++; $display("FAIL rsp_b: got %h required %h", {rsp_b_err, rsp_b_rdata}, exp_v);
        end
      end
    end
  end

  function automatic logic [W-1:0] expect_rsp(logic we, logic [4:0] addr, logic [DW-1:0] wdata);
    if (int'(addr) >= NW) return {1'b1, {DW{1'b0}}};
    if (we) begin
      if (addr != 5'd0) ref_mem[addr] = wdata;
      return '0;
    end
    return (addr == 5'd0) ? '0 : {1'b0, ref_mem[addr]};
  endfunction

  // Driver tasks
  task automatic set_a(input logic v, input logic we, input logic [4:0] addr, input logic [DW-1:0] d);
    a_valid = v; a_we = we; a_addr = addr; a_wdata = d;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [4:0] addr, input logic [DW-1:0] d);
    b_valid = v; b_we = we; b_addr = addr; b_wdata = d;
  endtask

  task automatic sample(output logic ga, output logic gb);
    @(negedge clk);
    ga = a_valid & a_ready;
    gb = b_valid & b_ready;
    if (ga) begin exp_a_q.push_back(expect_rsp(a_we, a_addr, a_wdata)); tb_last = 1'b0; end
    if (gb) begin exp_b_q.push_back(expect_rsp(b_we, b_addr, b_wdata)); tb_last = 1'b1; end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    logic ga, gb;
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    repeat (2) begin sample(ga, gb); step(); end
    checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      errors++; $display("FAIL drain: got %0d/%0d pending required 0/0", exp_a_q.size(), exp_b_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_ready, b_ready, rsp_a_valid, rsp_a_rdata, rsp_a_err, rsp_b_valid, rsp_b_rdata,
         rsp_b_err, scrub_busy, scrub_done, rf_addr, rf_wdata, rf_we, fsm_state} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero required all zero");
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    checks++;
    if ({fsm_state, scrub_busy, rf_we} !== 3'b000) begin
      errors++; $display("FAIL post_reset_idle: got %b required 000", {fsm_state, scrub_busy, rf_we});
    end
  endtask

  task automatic test_round_robin();
    logic ga, gb;
    set_a(1, 0, 3, 0); set_b(1, 0, 3, 0);
    sample(ga, gb);
    checks++;
    if ({ga, gb} !== 2'b10) begin errors++; $display("FAIL rr_first: got %b required 10", {ga, gb}); end
    step();
    sample(ga, gb);
    checks++;
    if ({ga, gb} !== 2'b01) begin errors++; $display("FAIL rr_second: got %b required 01", {ga, gb}); end
    step();
    set_a(0, 0, 0, 0);
    sample(ga, gb);
    checks++;
    if ({ga, gb, rsp_a_valid, rsp_b_valid} !== 4'b0101) begin
      errors++; $display("FAIL rr_rsp_timing: got %b required 0101", {ga, gb, rsp_a_valid, rsp_b_valid});
    end
    step();
    drain();
  endtask

  task automatic test_write_read();
    logic ga, gb;
    set_a(1, 1, 5, 32'hDEADBEEF);
    sample(ga, gb);
    checks++;
    if ({rf_we, rf_addr, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wr_path: got %b %0d %h required 1 5 deadbeef", rf_we, rf_addr, rf_wdata);
    end
    step();
    set_a(1, 0, 5, 0);
    sample(ga, gb);
    checks++;
    if ({rf_we, rf_addr} !== {1'b0, 5'd5}) begin
      errors++; $display("FAIL rd_path: got %b %0d required 0 5", rf_we, rf_addr);
    end
    step();
    drain();
  endtask

  task automatic test_errors();
    logic ga, gb;
    logic [4:0] addrs [4];
    logic       wes   [4];
    addrs = '{5'd28, 5'd31, 5'd0, 5'd0};
    wes   = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      set_b(1, wes[i], addrs[i], 32'h1234_0000 + 32'(i));
      sample(ga, gb);
      checks++;
      if ({gb, rf_we} !== 2'b10) begin
        errors++; $display("FAIL err_no_write_%0d: got gb=%b we=%b required gb=1 we=0", i, gb, rf_we);
      end
      step();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic ga, gb, exp_b;
    int na = 0;
    int nb = 0;
    for (int i = 0; i < 8; i++) begin
      exp_b = !tb_last;
      set_a(1, 1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), $urandom);
      set_b(1, 1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), $urandom);
      sample(ga, gb);
      checks++;
      if ({ga, gb} !== {!exp_b, exp_b}) begin
        errors++; $display("FAIL b2b_grant_%0d: got %b required %b", i, {ga, gb}, {!exp_b, exp_b});
      end
      na += int'(ga); nb += int'(gb);
      step();
    end
    checks++;
    if (na != 4 || nb != 4) begin errors++; $display("FAIL b2b_counts: got %0d/%0d required 4/4", na, nb); end
    drain();
  endtask

  task automatic test_scrub();
    logic ga, gb;
    int busy_cnt = 0;
    int done_cnt = 0;
    int last_busy = -1;
    int done_at = -1;
    int idx = 1;
    for (int i = 1; i < NW; i++) begin
      set_a(1, 1, 5'(i), 32'hA500_0000 | 32'(i));
      sample(ga, gb); step();
    end
    drain();
    scrub_req = 1'b1;
    set_a(1, 0, 1, 0);
    sample(ga, gb);
    checks++;
    if ({a_ready, b_ready, rf_we} !== 3'b000) begin
      errors++; $display("FAIL scrub_blocks_grant: got %b required 000", {a_ready, b_ready, rf_we});
    end
    step();
    scrub_req = 1'b0;
    set_a(0, 0, 0, 0);
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      if (scrub_busy) begin
        checks++;
        if ({rf_we, rf_addr, rf_wdata} !== {1'b1, 5'(idx), {DW{1'b0}}}) begin
          errors++; $display("FAIL scrub_write: got %b %0d %h required 1 %0d 0", rf_we, rf_addr, rf_wdata, idx);
        end
        idx++; busy_cnt++; last_busy = c;
      end
      if (scrub_done) begin done_cnt++; done_at = c; end
    end
    step();
    checks++;
    if (busy_cnt != NW - 1) begin errors++; $display("FAIL scrub_busy_len: got %0d required %0d", busy_cnt, NW - 1); end
    checks++;
    if (done_cnt != 1 || done_at != last_busy + 1) begin
      errors++; $display("FAIL scrub_done: got %0d pulses at %0d required 1 at %0d", done_cnt, done_at, last_busy + 1);
    end
    for (int i = 1; i < NW; i++) ref_mem[i] = '0;
    for (int i = 0; i < 32; i++) begin
      set_a(1, 0, 5'(i), 0);
      sample(ga, gb); step();
    end
    drain();
  endtask

  task automatic test_scrub_reset();
    logic ga, gb;
    logic found = 1'b0;
    for (int i = 1; i < 16; i++) begin
      set_a(1, 1, 5'(i), 32'h5A00_0000 | 32'(i));
      sample(ga, gb); step();
    end
    drain();
    scrub_req = 1'b1;
    sample(ga, gb); step();
    scrub_req = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (scrub_busy && rf_addr == 5'd10) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL scrub_reach_10: got not reached required reached"); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_ready, b_ready, rsp_a_valid, rsp_b_valid, scrub_busy, scrub_done, rf_addr, rf_wdata,
         rf_we, fsm_state} !== '0) begin
      errors++; $display("FAIL abort_outputs: got nonzero required all zero");
    end
    for (int i = 1; i < 10; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if ({fsm_state, scrub_busy, scrub_done} !== 3'b000) begin
      errors++; $display("FAIL abort_no_done: got %b required 000", {fsm_state, scrub_busy, scrub_done});
    end
    for (int i = 1; i < 16; i++) begin
      set_a(1, 0, 5'(i), 0);
      sample(ga, gb); step();
    end
    drain();
    scrub_req = 1'b1;
    sample(ga, gb); step();
    scrub_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({scrub_busy, rf_we, rf_addr} !== {2'b11, 5'd1}) begin
      errors++; $display("FAIL rescrub_start: got %b %b %0d required 1 1 1", scrub_busy, rf_we, rf_addr);
    end
    repeat (30) @(negedge clk);
    step();
    for (int i = 1; i < NW; i++) ref_mem[i] = '0;
    for (int i = 8; i < 12; i++) begin
      set_b(1, 0, 5'(i), 0);
      sample(ga, gb); step();
    end
    drain();
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      rf_mem[i] <= v;
      ref_mem[i] = v;
    end
    scrub_req = 1'b0;
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    test_reset();
    test_round_robin();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_scrub();
    test_scrub_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ibex_l2_rf_arbiter.md
Name: ibex_l2_rf_arbiter

Overview:
Controller that shares the single-port L2 register file between two requesters, A and B. A is the core spill/fill path; B is the debug/context-save path.
- Round-robin arbitration, one access per cycle.
- Registered read/write responses.
- Address range checking.
- Hardware scrub sequencer that zeroes every writable word on request.
Sits between the requesters and the L2 register file. It drives the file's addr/wdata/we and samples its combinational read data.

Parameters:
DataWidth, 32, word width; must equal the register file's DataWidth.
NumWords, 28, number of L2 word slots. Writable words are 1..NumWords-1; word 0 reads as zero.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_a_valid_i  in  1  requester A request valid
req_a_ready_o  out  1  requester A request accepted this cycle
req_a_we_i  in  1  A: 1=write, 0=read
req_a_addr_i  in  5  A word address
req_a_wdata_i  in  DataWidth  A write data
rsp_a_valid_o  out  1  A response valid, one-cycle pulse
rsp_a_rdata_o  out  DataWidth  A read data
rsp_a_err_o  out  1  A address error
req_b_* / rsp_b_*  same set as A, for requester B
scrub_req_i  in  1  request zeroing of all words
scrub_busy_o  out  1  scrub in progress
scrub_done_o  out  1  one-cycle pulse when scrub completes
rf_addr_o  out  5  register file address
rf_wdata_o  out  DataWidth  register file write data
rf_we_o  out  1  register file write enable
rf_rdata_i  in  DataWidth  register file combinational read data

Behaviour:
- Reset state: FSM=IDLE, scrub index=1, last_grant=B (so A wins first contention). All outputs 0.
- Reset asserted mid-scrub aborts the scrub: no done pulse, and words already zeroed stay zero.
- FSM states:
  - IDLE: arbitrate requests.
  - SCRUB: sequence zero writes.
- Arbitration (IDLE only):
  - If scrub_req_i=1, both ready_o=0 and the FSM enters SCRUB next cycle.
  - Otherwise:
    - Exactly one valid: that requester is granted.
    - Both valid: grant the requester not in last_grant.
  - ready_o is combinational and equals grant. A transfer occurs when valid&ready.
  - last_grant updates only on a transfer.
- Access path (combinational from the granted request):
  - rf_addr_o=addr, rf_wdata_o=wdata.
  - rf_we_o = we & (1<=addr<NumWords).
  - With no grant: rf_addr_o=0, rf_we_o=0, rf_wdata_o=0.
- Response, latency 1:
  - On the clock edge after a transfer, the granted side's rsp_valid_o=1 for exactly one cycle.
  - Read, addr<NumWords: rdata = rf_rdata_i sampled at the transfer edge; addr 0 returns 0. err=0.
  - Write, addr<NumWords: rdata=0, err=0. A write to addr 0 is dropped with no error.
  - addr>=NumWords (read or write): no register file write, rdata=0, err=1.
  - No response backpressure; requesters must accept responses. A new request may be accepted every cycle (fully pipelined).
  - rsp_valid_o for the side not granted is 0; its rdata/err hold their last values.
- SCRUB:
  - Each cycle: rf_addr_o=index, rf_wdata_o=0, rf_we_o=1, scrub_busy_o=1, both ready_o=0.
  - index increments from 1 to NumWords-1, so the scrub takes NumWords-1 cycles (27 at default).
  - The cycle after the write of index NumWords-1: FSM=IDLE, scrub_done_o=1 for one cycle, index reset to 1, scrub_busy_o=0.
  - scrub_req_i is ignored while in SCRUB.
  - If scrub_req_i is still high on return to IDLE, a new scrub starts (level-sensitive).
- Responses to transfers accepted before scrub entry still issue normally in the first SCRUB cycle.
- Read-after-write: a read issued the cycle after a write to the same address returns the new data.

Test Plan:
- Reset → all outputs 0. A and B both valid to read addr 3 → A granted first, B granted the next cycle (round-robin). Each rsp_valid pulses once, one cycle after its grant.
- A writes 0xDEADBEEF to addr 5, then reads addr 5 → rf_we_o=1 for one cycle at addr 5. Read response is 0xDEADBEEF with err=0.
- B writes addr 28, then reads addr 31 → rf_we_o stays 0 and both responses have err=1, rdata=0. Write to addr 0, then read addr 0 → rf_we_o=0, rdata=0, err=0.
- A and B both valid continuously for 8 cycles → grants alternate A,B,A,B…, four transfers each, no idle cycles.
- Fill words 1..27 with nonzero data, pulse scrub_req_i with A valid the same cycle → A is not granted. scrub_busy_o is high for exactly 27 cycles with addr 1..27 and we=1. Then scrub_done_o pulses once, and reads of every address return 0.
- Assert rst_ni low at scrub index 10 → all outputs 0 immediately, no scrub_done_o pulse. After release the FSM is IDLE and a new scrub starts at index 1.
